waveform_period_meter: RTL and testbench

- Receive-side counterpart to the team's DDS waveform generator: consumes a stream of 12-bit signed waveform samples (e.g. looped-back sin_out/squ_out, or ADC data) and measures the signal period in sample strobes.
- Detects rising zero crossings with hysteresis, accumulates NUM_PERIODS consecutive periods, and reports the sum and the average.
- Software/top-level converts period_avg to frequency or to an estimated phase_inc for the generator.

---
 rtl/waveform_period_meter.sv | 154 +++++++++++++++
 tb/tb_waveform_period_meter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_period_meter.sv
// waveform_period_meter
// Measures the period of a 12-bit signed waveform in sample strobes.
// Rising zero crossings are detected with hysteresis. NUM_PERIODS consecutive
// periods are summed and averaged, and the windows run back to back.
//
// Stream semantics: en is a qualifier with no backpressure. sample_in is
// consumed on every clk edge with en=1, and nothing happens on other edges.
// clr is a synchronous restart and overrides en. meas_valid and timeout are
// single-cycle pulses. locked is the FSM state (high in COUNT), registered.
module waveform_period_meter #(
  parameter int CNT_W       = 24,
  parameter int NUM_PERIODS = 4,
  parameter int HYST        = 64,
  parameter int MAX_PERIOD  = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [11:0]      sample_in,
  output logic [CNT_W-1:0] period_sum,
  output logic [CNT_W-1:0] period_avg,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam int LOG2_NP = $clog2(NUM_PERIODS);
  localparam int PC_W    = (LOG2_NP > 0) ? LOG2_NP : 1;

  localparam logic [PC_W-1:0]    PC_LAST  = PC_W'(NUM_PERIODS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_PERIOD - 1);
  localparam logic signed [12:0] HYST_S   = 13'(HYST);

  typedef enum logic {
    SEEK  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_acc;
  logic [PC_W-1:0]  r_pcount;
  logic [CNT_W-1:0] r_period_sum;
  logic [CNT_W-1:0] r_period_avg;
  logic             r_meas_valid;
  logic             r_timeout;
  logic             r_locked;

  logic signed [12:0] w_sample;
  logic               w_low;
  logic               w_high;
  logic               w_cross;
  logic [CNT_W-1:0]   w_period;
  logic [CNT_W:0]     w_acc_ext;
  logic [CNT_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   w_avg_next;

  // Sign-extend one bit so that -HYST_S is representable without overflow.
  assign w_sample = $signed({sample_in[11], sample_in});
  assign w_low    = (w_sample <= -HYST_S);
  assign w_high   = (w_sample >= HYST_S);
  assign w_cross  = r_armed & w_high;

  // The period includes the crossing sample itself, so it is cnt+1.
  assign w_period   = r_cnt + CNT_W'(1);
  assign w_acc_ext  = {1'b0, r_acc} + {1'b0, w_period};
  // Saturate instead of wrapping. This only matters for out-of-range settings.
  assign w_acc_next = w_acc_ext[CNT_W] ? {CNT_W{1'b1}} : w_acc_ext[CNT_W-1:0];
  assign w_avg_next = w_acc_next >> LOG2_NP;

  // SEEK/COUNT measurement FSM, hysteresis arming and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SEEK;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_pcount     <= '0;
      r_period_sum <= '0;
      r_period_avg <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      if (clr) begin
        // Restart the measurement but keep the last reported period.
        r_state  <= SEEK;
        r_armed  <= 1'b0;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_pcount <= '0;
        r_locked <= 1'b0;
      end else if (en) begin
        if (w_cross) begin
          r_armed <= 1'b0;
        end else if (w_low) begin
          r_armed <= 1'b1;
        end
        case (r_state)
          SEEK: begin
            r_cnt <= '0;
            if (w_cross) begin
              r_state  <= COUNT;
              r_locked <= 1'b1;
              r_acc    <= '0;
              r_pcount <= '0;
            end
          end
          COUNT: begin
            if (w_cross) begin
              // A crossing on the last allowed strobe wins over timeout.
              r_cnt <= '0;
              if (r_pcount == PC_LAST) begin
                r_period_sum <= w_acc_next;
                r_period_avg <= w_avg_next;
                r_meas_valid <= 1'b1;
                r_acc        <= '0;
                r_pcount     <= '0;
              end else begin
                r_acc    <= w_acc_next;
                r_pcount <= r_pcount + PC_W'(1);
              end
            end else if (r_cnt >= CNT_LAST) begin
              // Signal lost. armed is intentionally left as it is.
              r_timeout <= 1'b1;
              r_state   <= SEEK;
              r_locked  <= 1'b0;
              r_cnt     <= '0;
              r_acc     <= '0;
              r_pcount  <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state  <= SEEK;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period_sum = r_period_sum;
  assign period_avg = r_period_avg;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;
  assign locked     = r_locked;

endmodule

// File: tb/tb_waveform_period_meter.sv
// Testbench for waveform_period_meter.
// Directed waveforms drive the stimulus. Each expected measurement or timeout
// is queued with the strobe count at which it must appear. A monitor pops the
// queue and compares whenever meas_valid or timeout pulses.
module tb_waveform_period_meter;

  localparam int CNT_W = 24;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             clr;
  logic [11:0]      sample_in;
  logic [CNT_W-1:0] period_sum;
  logic [CNT_W-1:0] period_avg;
  logic             meas_valid;
  logic             timeout;
  logic             locked;

  always #5 clk = ~clk;

  waveform_period_meter #(
    .CNT_W(CNT_W), .NUM_PERIODS(4), .HYST(64), .MAX_PERIOD(1024)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .clr        (clr),
    .sample_in  (sample_in),
    .period_sum (period_sum),
    .period_avg (period_avg),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .locked     (locked)
  );

  int checks   = 0;
  int failures = 0;
  int strobe_n = 0;
  int base     = 0;

  // Entry layout: {sum[23:0], avg[23:0], strobe index[31:0]}.
  logic [2*CNT_W+31:0] exp_q[$];
  logic [31:0]         tmo_q[$];

  // Count the strobes that the DUT actually consumes.
  always @(posedge clk) begin
    if (reset_n && !clr && en) strobe_n <= strobe_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_meas(input int sum, input int avg, input int at);
    exp_q.push_back({24'(sum), 24'(avg), 32'(at)});
  endtask

  // Called on a negedge. Issues one strobe, then holds en low for gap cycles.
  task automatic strobe(input int v, input int gap);
    en = 1'b1;
    sample_in = 12'(v);
    @(negedge clk);
    repeat (gap) begin
      en = 1'b0;
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  // Square wave of +/-1000 with a given half-period, for indices first..first+n-1.
  task automatic square(input int half, input int first, input int n,
                        input bit start_low, input int gap);
    for (int i = first; i < first + n; i++) begin
      bit low;
      low = (((i / half) % 2) == 0) == start_low;
      strobe(low ? -1000 : 1000, gap);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL meas_unexpected: sum=%0d avg=%0d at strobe %0d, expected none",
                   period_sum, period_avg, strobe_n);
        end else begin
          logic [2*CNT_W+31:0] e;
          e = exp_q.pop_front();
          check("meas_sum", 32'(period_sum), 32'(e[79:56]));
          check("meas_avg", 32'(period_avg), 32'(e[55:32]));
          check("meas_strobe", 32'(strobe_n), e[31:0]);
        end
      end
      if (timeout) begin
        if (tmo_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL timeout_unexpected: at strobe %0d, expected none", strobe_n);
        end else begin
          logic [31:0] t;
          t = tmo_q.pop_front();
          check("timeout_strobe", 32'(strobe_n), t);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    sample_in = '0;
    repeat (3) @(negedge clk);
    check("rst_sum", 32'(period_sum), 0);
    check("rst_avg", 32'(period_avg), 0);
    check("rst_mv", 32'(meas_valid), 0);
    check("rst_tmo", 32'(timeout), 0);
    check("rst_locked", 32'(locked), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Square wave with half-period 4, one strobe every cycle.
    base = strobe_n;
    push_meas(32, 8, base + 37);
    push_meas(32, 8, base + 69);
    square(4, 0, 4, 1'b1, 0);
    check("sq_lock_before", 32'(locked), 0);
    square(4, 4, 1, 1'b1, 0);
    check("sq_lock_after", 32'(locked), 1);
    square(4, 5, 67, 1'b1, 0);
    check("sq_drain", exp_q.size(), 0);
    check("sq_sum_hold", 32'(period_sum), 32);
    do_clr();
    check("sq_clr_unlock", 32'(locked), 0);

    // Same wave with strobes one cycle in three.
    base = strobe_n;
    push_meas(32, 8, base + 37);
    push_meas(32, 8, base + 69);
    square(4, 0, 72, 1'b1, 2);
    check("gap_drain", exp_q.size(), 0);
    do_clr();

    // +/-50 noise stays inside the hysteresis band.
    for (int i = 0; i < 500; i++) strobe((i % 2) ? -50 : 50, 0);
    check("noise_no_lock", 32'(locked), 0);
    base = strobe_n;
    push_meas(40, 10, base + 46);
    square(5, 0, 50, 1'b1, 0);
    check("hyst_drain", exp_q.size(), 0);
    check("hyst_locked", 32'(locked), 1);

    // Timeout: the last crossing was strobe base+46, then 1024 strobes pass.
    tmo_q.push_back(32'(base + 1070));
    repeat (1019) strobe(-1000, 0);
    check("tmo_lock_pre", 32'(locked), 1);
    check("tmo_not_early", tmo_q.size(), 1);
    repeat (2) strobe(-1000, 0);
    check("tmo_drain", tmo_q.size(), 0);
    check("tmo_unlock", 32'(locked), 0);
    check("tmo_sum_hold", 32'(period_sum), 40);
    check("tmo_avg_hold", 32'(period_avg), 10);
    // armed survives the timeout, so the first high sample relocks at once.
    base = strobe_n;
    push_meas(40, 10, base + 41);
    square(5, 0, 1, 1'b0, 0);
    check("tmo_relock", 32'(locked), 1);
    square(5, 1, 45, 1'b0, 0);
    check("relock_drain", exp_q.size(), 0);

    // clr after two periods of a new window.
    square(5, 46, 15, 1'b0, 0);
    do_clr();
    check("clr_unlock", 32'(locked), 0);
    check("clr_no_meas", exp_q.size(), 0);
    base = strobe_n;
    push_meas(40, 10, base + 46);
    square(5, 0, 40, 1'b1, 0);
    check("clr_not_early", exp_q.size(), 1);
    square(5, 40, 10, 1'b1, 0);
    check("clr_drain", exp_q.size(), 0);

    // Asynchronous reset while in COUNT, applied away from any clk edge.
    square(5, 50, 3, 1'b1, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sum", 32'(period_sum), 0);
    check("arst_avg", 32'(period_avg), 0);
    check("arst_mv", 32'(meas_valid), 0);
    check("arst_tmo", 32'(timeout), 0);
    check("arst_locked", 32'(locked), 0);
    @(negedge clk);
    reset_n = 1'b1;
    strobe(1000, 0);
    check("arst_no_relock_unarmed", 32'(locked), 0);
    square(5, 0, 6, 1'b1, 0);
    check("arst_relock", 32'(locked), 1);

    repeat (3) @(negedge clk);
    check("final_meas_q", exp_q.size(), 0);
    check("final_tmo_q", tmo_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
